// File: rtl/io_bus_bridge.sv
// io_bus_bridge
// Bridges CPU accesses to the I/O address space onto the I/O bus master and
// reports completion to the front-side bus controller through Ready/BERR.
// One request per I/O access. A watchdog turns a hung request into a bus error.
//
// Build option: IOB_POSTED_WRITE_EN
//   defined   - writes are posted: the CPU gets Ready at once, and the bridge
//               finishes the write in state WR. An error on a posted write is
//               remembered in werr and reported to the next I/O cycle as BERR.
//   undefined - writes take the same path as reads, and the CPU waits.
//
// Ports
//   FCLK          CPU-side clock, rising edge
//   Reset         asynchronous, active-high
//   BACT          bus cycle active
//   IOCS          address is in I/O space (valid while BACT)
//   nWE           write strobe, 0 = write (valid while BACT)
//   IOREQ         level request to the I/O master
//   IORW          latched direction of the outstanding request, 1 = read
//   ALE           one-cycle latch enable for the address/data holding registers
//   IODONE        completion pulse from the I/O master
//   IOBERR        error pulse from the I/O master
//   Ready, BERR   to the FSB Ready and BERR inputs
//
// state | meaning
// IDLE  | no request outstanding, accepts a new I/O cycle
// RD    | request outstanding, CPU waiting for the result
// WR    | posted write outstanding, CPU already released
// HOLD  | Ready/BERR given, waiting for BACT to drop
module io_bus_bridge #(
    parameter int TIMEOUT = 200
) (
    input  logic FCLK,
    input  logic Reset,
    input  logic BACT,
    input  logic IOCS,
    input  logic nWE,
    output logic IOREQ,
    output logic IORW,
    output logic ALE,
    input  logic IODONE,
    input  logic IOBERR,
    output logic Ready,
    output logic BERR
);

    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RD, WR, HOLD} state_t;

    state_t     state;
    logic [9:0] cnt;
    logic       ack;
    logic       abandon;    // BACT dropped while the CPU was waiting; discard the result
    logic       ready_r;
    logic       berr_r;
`ifdef IOB_POSTED_WRITE_EN
    logic       werr;
`endif

    logic new_cyc;
    logic tmo;
    logic term;

    assign new_cyc = BACT & IOCS & ~ack;
    assign tmo     = IOREQ & (cnt == TMO_LAST);
    assign term    = IODONE | IOBERR | tmo;

    // Non-I/O cycles are acknowledged combinationally. Every other case is registered.
    assign Ready = ready_r | (BACT & ~IOCS);
    assign BERR  = berr_r;

    always_ff @(posedge FCLK or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            abandon <= 1'b0;
            ready_r <= 1'b0;
            berr_r  <= 1'b0;
            IOREQ   <= 1'b0;
            IORW    <= 1'b1;
            ALE     <= 1'b0;
`ifdef IOB_POSTED_WRITE_EN
            werr    <= 1'b0;
`endif
        end else begin
            ALE <= 1'b0;
            if (IOREQ)
                cnt <= cnt + 10'd1;
            // The end of the CPU cycle always clears the acknowledge.
            // Assignments made later in this block take precedence.
            if (!BACT) begin
                ack     <= 1'b0;
                ready_r <= 1'b0;
                berr_r  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (new_cyc) begin
`ifdef IOB_POSTED_WRITE_EN
                        if (werr) begin
                            // Report the failed posted write to this cycle instead.
                            berr_r <= 1'b1;
                            ack    <= 1'b1;
                            werr   <= 1'b0;
                            state  <= HOLD;
                        end else begin
                            ALE     <= 1'b1;
                            IOREQ   <= 1'b1;
                            IORW    <= nWE;
                            cnt     <= '0;
                            abandon <= 1'b0;
                            if (!nWE) begin
                                ready_r <= 1'b1;
                                ack     <= 1'b1;
                                state   <= WR;
                            end else begin
                                state   <= RD;
                            end
                        end
`else
                        ALE     <= 1'b1;
                        IOREQ   <= 1'b1;
                        IORW    <= nWE;
                        cnt     <= '0;
                        abandon <= 1'b0;
                        state   <= RD;
`endif
                    end
                end

                RD: begin
                    if (!BACT)
                        abandon <= 1'b1;
                    if (term) begin
                        IOREQ <= 1'b0;
                        if (abandon || !BACT) begin
                            state <= IDLE;
                        end else begin
                            ack   <= 1'b1;
                            state <= HOLD;
                            // An error beats a completion in the same cycle.
                            if (IOBERR || tmo)
                                berr_r  <= 1'b1;
                            else
                                ready_r <= 1'b1;
                        end
                    end
                end

`ifdef IOB_POSTED_WRITE_EN
                WR: begin
                    if (term) begin
                        IOREQ <= 1'b0;
                        if (IOBERR || tmo)
                            werr <= 1'b1;
                        // The write's own CPU cycle may still be open.
                        state <= (ack && BACT) ? HOLD : IDLE;
                    end
                end
`endif

                HOLD: begin
                    if (!BACT)
                        state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
